// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RV32 control unit.
// Holds the state encoding, opcodes, ALU codes and mux select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Per-state control bundle, before step/reset gating.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    // Where DECODE dispatches to for a given opcode.
    function automatic state_t decode_target(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_LW,
            OP_SW:   nxt = S_MEMADR;
            OP_R:    nxt = S_EXECR;
            OP_I:    nxt = S_EXECI;
            OP_BEQ:  nxt = S_BEQ;
            default: nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode for register and immediate ALU instructions.
// Purely combinational; the FSM decides when its result is used.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_ctrl_o
);

    logic is_sub;

    assign is_sub = funct7b5_i && (op_i == OP_R);

    // funct3 picks the operation; funct7b5 splits add/sub for R-type only
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (funct3_i)
            F3_ADD:  alu_ctrl_o = is_sub ? ALU_SUB : ALU_ADD;
            F3_SLT:  alu_ctrl_o = ALU_SLT;
            F3_OR:   alu_ctrl_o = ALU_OR;
            F3_AND:  alu_ctrl_o = ALU_AND;
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM (lw, sw, R-type, I-type ALU, beq).
// Outputs decode the state register; write strobes gate on step/reset.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       step_en,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic [3:0] state_o,
    output logic       retire,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic [2:0] alu_dec;
    logic [2:0] alu_sel;
    logic       wr_ok;

    alu_decoder u_alu_dec (
        .op_i       (op),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .alu_ctrl_o (alu_dec)
    );

    // Next-state selection; step_en low freezes the FSM
    always_comb begin
        state_d = state_q;
        if (step_en) begin
            case (state_q)
                S_FETCH:    state_d = S_DECODE;
                S_DECODE:   state_d = decode_target(op);
                S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD
                                                    : S_MEMWRITE;
                S_MEMREAD:  state_d = S_MEMWB;
                S_MEMWB:    state_d = S_FETCH;
                S_MEMWRITE: state_d = S_FETCH;
                S_EXECR:    state_d = S_ALUWB;
                S_EXECI:    state_d = S_ALUWB;
                S_ALUWB:    state_d = S_FETCH;
                S_BEQ:      state_d = S_FETCH;
                default:    state_d = S_HALT;
            endcase
        end
    end

    // State register; reset wins over everything, including HALT
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state control decode; beq is the only state using zero
    always_comb begin
        ctrl    = '0;
        alu_sel = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.adr_src    = ADR_PC;
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                ctrl.pc_write   = 1'b1;
                alu_sel         = ALU_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.imm_src    = IMM_B;
                alu_sel         = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.imm_src    = (op == OP_SW) ? IMM_S : IMM_I;
                alu_sel         = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = ADR_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = ADR_ALUOUT;
                ctrl.mem_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                alu_sel         = alu_dec;
            end
            S_EXECI: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.imm_src    = IMM_I;
                alu_sel         = alu_dec;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
                ctrl.retire     = 1'b1;
                alu_sel         = ALU_SUB;
            end
            default: begin
                ctrl.illegal    = 1'b1;
            end
        endcase
    end

    // Strobes only fire out of reset and while the FSM is advancing
    assign wr_ok       = rst & step_en;

    assign pc_write    = ctrl.pc_write  & wr_ok;
    assign ir_write    = ctrl.ir_write  & wr_ok;
    assign reg_write   = ctrl.reg_write & wr_ok;
    assign mem_write   = ctrl.mem_write & wr_ok;
    assign retire      = ctrl.retire    & wr_ok;
    assign illegal     = ctrl.illegal   & rst;

    assign adr_src     = ctrl.adr_src;
    assign result_src  = ctrl.result_src;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign imm_src     = ctrl.imm_src;
    assign alu_control = alu_sel;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle output expectations
// and per-instruction latency expectations, popped by a monitor.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       step_en;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic [3:0] state_o;
    logic       retire;
    logic       illegal;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic       regw;
        logic [2:0] alu;
        logic       ret;
        logic       ill;
    } obs_t;

    obs_t   exp_q[$];
    int     lat_q[$];
    state_t ph;
    int     n_chk  = 0;
    int     n_pass = 0;
    int     cnt    = 0;
    int     cyc    = 0;
    obs_t   e_o;
    obs_t   g_o;
    int     l_exp;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .step_en     (step_en),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .alu_control (alu_control),
        .state_o     (state_o),
        .retire      (retire),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Instruction class -> ordered list of phases it walks through.
    function automatic state_t next_phase(state_t cur, logic [6:0] o);
        state_t p[5];
        int     n;
        state_t nx;
        p = '{S_FETCH, S_DECODE, S_HALT, S_HALT, S_HALT};
        n = 3;
        case (o)
            7'b0000011: begin
                p = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
                n = 5;
            end
            7'b0100011: begin
                p = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_HALT};
                n = 4;
            end
            7'b0110011: begin
                p = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_HALT};
                n = 4;
            end
            7'b0010011: begin
                p = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_HALT};
                n = 4;
            end
            7'b1100011: begin
                p = '{S_FETCH, S_DECODE, S_BEQ, S_HALT, S_HALT};
                n = 3;
            end
            default: ;
        endcase
        nx = S_HALT;
        if (cur != S_HALT) begin
            for (int i = 0; i < n; i++) begin
                if (p[i] == cur) nx = (i == n - 1) ? S_FETCH : p[i + 1];
            end
        end
        return nx;
    endfunction

    function automatic int latency_of(logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011: return 4;
            7'b0010011: return 4;
            7'b1100011: return 3;
            default:    return 0;
        endcase
    endfunction

    // What the ALU should do for an ALU-class instruction.
    function automatic logic [2:0] alu_op(logic [6:0] o, logic [2:0] f3,
                                          logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic obs_t model_out(state_t p, logic [6:0] o,
                                       logic [2:0] f3, logic f7,
                                       logic z, logic r, logic s);
        obs_t e;
        e    = '0;
        e.st = p;
        case (p)
            S_FETCH: begin
                e.irw = 1; e.sb = 2'b10; e.res = 2'b10; e.pcw = 1;
            end
            S_DECODE: begin
                e.sa = 2'b01; e.sb = 2'b01; e.imm = 2'b10;
            end
            S_MEMADR: begin
                e.sa  = 2'b10; e.sb = 2'b01;
                e.imm = (o == 7'b0100011) ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  e.adr = 1;
            S_MEMWB: begin
                e.res = 2'b01; e.regw = 1; e.ret = 1;
            end
            S_MEMWRITE: begin
                e.adr = 1; e.memw = 1; e.ret = 1;
            end
            S_EXECR: begin
                e.sa = 2'b10; e.alu = alu_op(o, f3, f7);
            end
            S_EXECI: begin
                e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_op(o, f3, f7);
            end
            S_ALUWB: begin
                e.regw = 1; e.ret = 1;
            end
            S_BEQ: begin
                e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.ret = 1;
            end
            default: e.ill = 1;
        endcase
        if (!r || !s) begin
            e.pcw = 0; e.irw = 0; e.regw = 0; e.memw = 0; e.ret = 0;
        end
        if (!r) e.ill = 0;
        return e;
    endfunction

    // One clock of stimulus: queue the expectation, then advance model.
    task automatic drive(input logic r, input logic s, input logic z);
        rst     = r;
        step_en = s;
        zero    = z;
        exp_q.push_back(model_out(ph, op, funct3, funct7b5, z, r, s));
        @(posedge clk);
        #1;
        if (!r) ph = S_FETCH;
        else if (s) ph = next_phase(ph, op);
    endtask

    task automatic reset_cycle();
        lat_q.delete();
        drive(1'b0, 1'b1, 1'b0);
    endtask

    // zsel: 0/1 fixed zero flag, 2 random; rnd adds stalls and resets.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input bit rnd,
                             input int zsel);
        bit   left;
        bit   done;
        logic r;
        logic s;
        logic z;
        int   lat;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        lat      = latency_of(o);
        if (lat > 0) lat_q.push_back(lat);
        left = 0;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            s = rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? logic'($urandom_range(0, 59) != 0) : 1'b1;
            z = (zsel == 2) ? logic'($urandom_range(0, 1))
                            : logic'(zsel == 1);
            if (!r) lat_q.delete();
            drive(r, s, z);
            if (!r) done = 1;
            else if (ph == S_HALT) done = 1;
            else if (ph != S_FETCH) left = 1;
            else if (left) done = 1;
        end
        n_chk++;
        if (done) n_pass++;
        else $display("FAIL instr_bound op=%b: still in %0d, required done",
                      o, ph);
    endtask

    task automatic run_word(input logic [31:0] w, input int zsel);
        run_instr(w[6:0], w[14:12], w[30], 1'b0, zsel);
    endtask

    task automatic sit_in_halt(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b1, logic'($urandom_range(0, 1)), 1'b1);
    endtask

    // Monitor: compare outputs every cycle, and latency on each retire
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e_o = exp_q.pop_front();
                g_o = '{state_o, pc_write, adr_src, mem_write, ir_write,
                        result_src, alu_src_a, alu_src_b, imm_src,
                        reg_write, alu_control, retire, illegal};
                n_chk++;
                if (g_o === e_o) n_pass++;
                else $display("FAIL outputs cyc=%0d st=%0d: got %h required %h",
                              cyc, e_o.st, g_o, e_o);
            end
            if (rst !== 1'b1) begin
                cnt = 0;
            end else begin
                if (step_en) cnt++;
                if (retire === 1'b1) begin
                    n_chk++;
                    if (lat_q.size() == 0) begin
                        $display("FAIL retire cyc=%0d: got retire, required none",
                                 cyc);
                    end else begin
                        l_exp = lat_q.pop_front();
                        if (cnt == l_exp) n_pass++;
                        else $display("FAIL latency cyc=%0d: got %0d required %0d",
                                      cyc, cnt, l_exp);
                    end
                    cnt = 0;
                end
            end
        end
    end

    logic [6:0] bad_ops [4];
    logic [6:0] rop;
    int         cls;

    initial begin
        bad_ops  = '{7'h7f, 7'h37, 7'h6f, 7'h00};
        rst      = 1'b0;
        step_en  = 1'b1;
        zero     = 1'b0;
        op       = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        ph       = S_FETCH;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        reset_cycle();
        run_word(32'h00402083, 2);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 2);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 2);
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 1'b1);
        reset_cycle();

        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        lat_q.push_back(4);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);

        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        lat_q.push_back(5);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        reset_cycle();

        for (int f = 0; f < 8; f++) begin
            run_instr(7'b0110011, 3'(f), 1'b1, 1'b0, 2);
            run_instr(7'b0010011, 3'(f), 1'b1, 1'b0, 2);
        end

        for (int n = 0; n < 250; n++) begin
            cls = $urandom_range(0, 19);
            if (cls < 4)       rop = 7'b0000011;
            else if (cls < 8)  rop = 7'b0100011;
            else if (cls < 12) rop = 7'b0110011;
            else if (cls < 16) rop = 7'b0010011;
            else if (cls < 19) rop = 7'b1100011;
            else               rop = bad_ops[$urandom_range(0, 3)];
            run_instr(rop, 3'($urandom_range(0, 7)),
                      logic'($urandom_range(0, 1)), 1'b1, 2);
            if (ph == S_HALT) begin
                sit_in_halt($urandom_range(1, 6));
                reset_cycle();
            end
        end

        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain_exp: got %0d left, required 0", exp_q.size());
        n_chk++;
        if (lat_q.size() == 0) n_pass++;
        else $display("FAIL drain_lat: got %0d left, required 0", lat_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
